// File: rtl/multicycle_controller_pkg.sv
// mips_ctrl_pkg: FSM state, opcode/func, aluop and npc_slc encodings plus the one-hot instruction class shared by the controller
package mips_ctrl_pkg;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXE = 3'd3, S_MEM = 3'd4, S_WB = 3'd5;
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_JR = 6'b001000, FN_NOP = 6'b000000;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_OR = 3'b010;
  localparam logic [2:0] NPC_PC4 = 3'b000, NPC_BR = 3'b001, NPC_JMP = 3'b010, NPC_GPR = 3'b011;
  typedef struct packed {
    logic is_addu;
    logic is_subu;
    logic is_jr;
    logic is_nop;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic is_jal;
    logic is_illegal;
  } instr_t;
endpackage

// File: rtl/multicycle_controller_decode.sv
// instr_decode: combinational opc/func -> one-hot instruction class (i_opc, i_func in; o_cls out)
module instr_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opc,
  input  logic [5:0] i_func,
  output instr_t     o_cls
);
  logic w_r;
  assign w_r = i_opc == OP_RTYPE;
  always_comb begin
    o_cls = '0;
    o_cls.is_addu = w_r && i_func == FN_ADDU;
    o_cls.is_subu = w_r && i_func == FN_SUBU;
    o_cls.is_jr = w_r && i_func == FN_JR;
    o_cls.is_nop = w_r && i_func == FN_NOP;
    o_cls.is_ori = i_opc == OP_ORI;
    o_cls.is_lui = i_opc == OP_LUI;
    o_cls.is_lw = i_opc == OP_LW;
    o_cls.is_sw = i_opc == OP_SW;
    o_cls.is_beq = i_opc == OP_BEQ;
    o_cls.is_j = i_opc == OP_J;
    o_cls.is_jal = i_opc == OP_JAL;
    o_cls.is_illegal = ~|o_cls[11:1];
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: MIPS32 multi-cycle FSM (clk, async active-low reset, opc/func/zero/ready in; memory requests, datapath controls, illegal pulse, retired count out)
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opc,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             pcwr,
  output logic             irwr,
  output logic             regwrite,
  output logic             memwrite,
  output logic             regdst,
  output logic             alusrc,
  output logic             memtoreg,
  output logic             extop,
  output logic             luiop,
  output logic [2:0]       aluop,
  output logic [2:0]       npc_slc,
  output logic             jalop,
  output logic             jrop,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  logic [2:0] r_state, w_next;
  logic [CNT_W-1:0] r_retired;
  instr_t w_c;
  logic w_fetch, w_dec, w_exe, w_mem, w_wb, w_jmp, w_short, w_ldst, w_retire;
  instr_decode u_dec (.i_opc(opc), .i_func(func), .o_cls(w_c));
  assign w_fetch = r_state == S_FETCH;
  assign w_dec = r_state == S_DECODE;
  assign w_exe = r_state == S_EXE;
  assign w_mem = r_state == S_MEM;
  assign w_wb = r_state == S_WB;
  assign w_jmp = w_c.is_j | w_c.is_jal;
  assign w_short = w_jmp | w_c.is_jr | w_c.is_nop | w_c.is_illegal;
  assign w_ldst = w_c.is_lw | w_c.is_sw;
  assign imem_req = w_fetch;
  assign irwr = w_fetch & imem_ready;
  assign pcwr = irwr | (w_dec & (w_jmp | w_c.is_jr)) | (w_exe & w_c.is_beq & zero);
  assign npc_slc = w_dec & w_jmp ? NPC_JMP : w_dec & w_c.is_jr ? NPC_GPR : w_exe & w_c.is_beq ? NPC_BR : NPC_PC4;
  assign regwrite = (w_dec & w_c.is_jal) | w_wb;
  assign jalop = w_dec & w_c.is_jal;
  assign jrop = w_dec & w_c.is_jr;
  assign illegal = w_dec & w_c.is_illegal;
  assign dmem_req = w_mem;
  assign memwrite = w_mem & w_c.is_sw;
  assign aluop = w_exe & (w_c.is_subu | w_c.is_beq) ? ALU_SUB : w_exe & w_c.is_ori ? ALU_OR : ALU_ADD;
  assign alusrc = (w_exe & (w_c.is_ori | w_ldst)) | w_mem;
  assign extop = (w_exe & (w_ldst | w_c.is_beq)) | w_mem;
  assign luiop = (w_exe | w_wb) & w_c.is_lui;
  assign regdst = w_wb & (w_c.is_addu | w_c.is_subu);
  assign memtoreg = w_wb & w_c.is_lw;
  assign w_retire = (w_dec & w_short & ~w_c.is_illegal) | (w_exe & w_c.is_beq) | (w_mem & dmem_ready & w_c.is_sw) | w_wb;
  assign retired = r_retired;
  always_comb begin
    w_next = r_state == S_IDLE ? S_FETCH :
             w_fetch ? (imem_ready ? S_DECODE : S_FETCH) :
             w_dec ? (w_short ? S_FETCH : S_EXE) :
             w_exe ? (w_c.is_beq ? S_FETCH : w_ldst ? S_MEM : S_WB) :
             w_mem ? (dmem_ready ? (w_c.is_sw ? S_FETCH : S_WB) : S_MEM) :
             w_wb ? S_FETCH : S_IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_retired <= r_retired + CNT_W'(w_retire);
    end
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle FSM controller for the MIPS32 datapath; replaces the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXE/MEM/WB.
- Drives PC/IR write enables, register-file and memory controls, ALU and next-PC selects.
- Handshakes with instruction and data memories through req/ready; counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opc  in  6  IR[31:26], from the registered IR
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in EXE
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- pcwr  out  1  PC write enable
- irwr  out  1  IR write enable
- regwrite  out  1  register file write enable
- memwrite  out  1  data memory write (qualifies dmem_req)
- regdst  out  1  1 = rd, 0 = rt
- alusrc  out  1  1 = extended immediate
- memtoreg  out  1  1 = write-back from memory data register
- extop  out  1  1 = sign extend, 0 = zero extend
- luiop  out  1  write-back selects imm<<16
- aluop  out  3  000 add, 001 sub, 010 or
- npc_slc  out  3  000 PC+4, 001 branch, 010 j/jal target, 011 GPR[rs]
- jalop  out  1  write PC+4 to $31
- jrop  out  1  jump-register cycle
- illegal  out  1  1-cycle pulse on unsupported instruction
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Supported instructions:
  - addu: op 000000, func 100001
  - subu: op 000000, func 100011
  - jr: op 000000, func 001000
  - nop: op 000000, func 000000
  - ori: op 001101
  - lui: op 001111
  - lw: op 100011
  - sw: op 101011
  - beq: op 000100
  - j: op 000010
  - jal: op 000011
- Reset (reset=0, async): state=IDLE, retired=0. All outputs are Moore-decoded from state plus opc/func, so every output is 0 in IDLE.
- IDLE: all outputs 0; next cycle goes to FETCH.
- FETCH:
  - imem_req=1; hold while imem_ready=0.
  - On imem_ready=1, same cycle: irwr=1, pcwr=1, npc_slc=000; go to DECODE.
  - Min latency 1 cycle.
- DECODE:
  - j: pcwr=1, npc_slc=010, retire; go to FETCH.
  - jal: pcwr=1, npc_slc=010, regwrite=1, jalop=1, retire; go to FETCH.
  - jr: pcwr=1, npc_slc=011, jrop=1, retire; go to FETCH.
  - nop: retire; go to FETCH.
  - Unsupported: illegal=1, no writes, not retired; go to FETCH.
  - All other instructions go to EXE.
- EXE:
  - addu/subu: aluop 000/001, alusrc=0; go to WB.
  - ori: aluop=010, alusrc=1, extop=0; go to WB.
  - lui: luiop=1; go to WB.
  - lw/sw: aluop=000, alusrc=1, extop=1; go to MEM.
  - beq: aluop=001, alusrc=0, extop=1, npc_slc=001; pcwr=zero; retire; go to FETCH.
- MEM:
  - dmem_req=1, memwrite=(sw); aluop/alusrc/extop held from EXE; hold while dmem_ready=0.
  - On dmem_ready=1: sw retires and goes to FETCH; lw goes to WB.
- WB:
  - regwrite=1 for exactly 1 cycle.
  - regdst=1 for addu/subu, else 0; memtoreg=1 for lw; luiop=1 for lui.
  - Retire; go to FETCH.
- CPI: j/jal/jr = 2; beq = 3; ALU ops = 4; sw = 4; lw = 5 (zero-wait memories).
- Retired counter: +1 on each retire event; wraps 2^CNT_W-1 → 0.
- Asserting reset mid-instruction aborts it: no further pcwr/regwrite/memwrite; returns to IDLE.
- opc/func must stay stable from DECODE through WB (IR only written in FETCH). Controller never asserts irwr outside FETCH.
- At most one of imem_req/dmem_req is high in any cycle. Any ready input asserted outside its request state is ignored.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings: IDLE, FETCH, DECODE, EXE, MEM, WB
  - opcode/func constants
  - aluop and npc_slc encodings
- One sub-module, instr_decode: combinational opc/func → one-hot instruction class (is_addu … is_jal, is_illegal), instantiated once by the FSM.

Test Plan:
- Reset released, imem_ready=1, IR=ori (opc 001101) → IDLE, FETCH(irwr=pcwr=1), DECODE, EXE(aluop=010, alusrc=1, extop=0), WB(regwrite=1, regdst=0); retired=1 after 5 cycles.
- lw with dmem_ready low for 3 MEM cycles → dmem_req held 4 cycles, memwrite=0; then WB with memtoreg=1; no regwrite before WB.
- beq with zero=1 then zero=0 → EXE pcwr=1 / pcwr=0, npc_slc=001 both times; 3 cycles each; retired +2.
- jal then jr → DECODE: pcwr=1, npc_slc=010, jalop=1, regwrite=1; then pcwr=1, npc_slc=011, jrop=1; 2 cycles each.
- opc=111111 → illegal pulses 1 cycle in DECODE; pcwr/regwrite/memwrite all 0; retired unchanged; next cycle FETCH.
- reset asserted during sw MEM wait → outputs 0 immediately (async); state IDLE; retired=0; memwrite never seen with dmem_ready.
